// File: rtl/sc_neuron_scheduler_if.sv
// sc_neuron_scheduler_if: control, neuron-stream and result handshake signals of the scheduler.
// The master side is the layer sequencer / environment; the slave side is the scheduler.
interface sc_neuron_scheduler_if #(
    parameter int unsigned IW = 2,
    parameter int unsigned CW = 9
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [IW-1:0] neu_sel;
    logic          neu_rst_n;
    logic          stream_en;
    logic          neu_dout;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_idx;
    logic [CW-1:0] res_count;

    modport master (
        output start, abort, neu_dout, res_ready,
        input  busy, done, neu_sel, neu_rst_n, stream_en, res_valid, res_idx, res_count
    );

    modport slave (
        input  start, abort, neu_dout, res_ready,
        output busy, done, neu_sel, neu_rst_n, stream_en, res_valid, res_idx, res_count
    );
endinterface

// File: rtl/sc_neuron_scheduler.sv
// sc_neuron_scheduler: time-multiplexes one stochastic APC neuron datapath across M neurons.
// Optional build macro SC_WARMUP_EN: the first WU samples of each stream are not counted.
module sc_neuron_scheduler #(
    parameter int unsigned M  = 4,
    parameter int unsigned L  = 256,
    parameter int unsigned WU = 16,
    parameter int unsigned IW = (M > 1) ? $clog2(M) : 1,
    parameter int unsigned CW = $clog2(L + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    sc_neuron_scheduler_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]    r_state, w_state_next;
    logic [IW-1:0] r_neu_sel, w_neu_sel_next;
    logic [CW-1:0] r_cyc, w_cyc_next;
    logic [CW-1:0] r_ones, w_ones_next;
    logic          w_count_en;
    logic          w_inc;

`ifdef SC_WARMUP_EN
    // Warm-up samples only settle the neuron's saturating counter.
    assign w_count_en = (r_cyc >= CW'(WU));
`else
    logic w_unused_wu;
    assign w_unused_wu = |WU;
    assign w_count_en  = 1'b1;
`endif

    assign w_inc = bus.neu_dout & w_count_en;

    always_comb begin
        w_state_next   = r_state;
        w_neu_sel_next = r_neu_sel;
        w_cyc_next     = r_cyc;
        w_ones_next    = r_ones;
        if (bus.abort) begin
            // Abort dominates start and drops any result held in OUT.
            w_state_next   = S_IDLE;
            w_neu_sel_next = '0;
            w_cyc_next     = '0;
            w_ones_next    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next   = S_INIT;
                        w_neu_sel_next = '0;
                    end
                end
                S_INIT: begin
                    w_cyc_next   = '0;
                    w_ones_next  = '0;
                    w_state_next = S_RUN;
                end
                S_RUN: begin
                    w_cyc_next  = r_cyc + CW'(1);
                    w_ones_next = r_ones + {{(CW-1){1'b0}}, w_inc};
                    if (r_cyc == CW'(L - 1)) begin
                        w_state_next = S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        if (r_neu_sel == IW'(M - 1)) begin
                            w_state_next = S_FIN;
                        end else begin
                            w_neu_sel_next = r_neu_sel + IW'(1);
                            w_state_next   = S_INIT;
                        end
                    end
                end
                S_FIN:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_neu_sel <= '0;
            r_cyc     <= '0;
            r_ones    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_neu_sel <= w_neu_sel_next;
            r_cyc     <= w_cyc_next;
            r_ones    <= w_ones_next;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FIN);
    assign bus.neu_sel   = r_neu_sel;
    assign bus.neu_rst_n = (r_state == S_RUN) || (r_state == S_OUT);
    assign bus.stream_en = (r_state == S_RUN);
    assign bus.res_valid = (r_state == S_OUT);
    assign bus.res_idx   = r_neu_sel;
    assign bus.res_count = r_ones;
endmodule

// File: tb/tb_sc_neuron_scheduler.sv
// tb_sc_neuron_scheduler: directed pass sequence with random neuron bitstreams, checked
// against a cycle schedule and per-neuron ones counts derived from the stream contents.
module tb_sc_neuron_scheduler;
    localparam int unsigned M  = 4;
    localparam int unsigned L  = 256;
    localparam int unsigned WU = 16;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 9;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   bits[L];

    sc_neuron_scheduler_if #(.IW(IW), .CW(CW)) bus ();

    sc_neuron_scheduler #(.M(M), .L(L), .WU(WU), .IW(IW), .CW(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bits(input int mode);
        for (int i = 0; i < L; i++) begin
            case (mode)
                0:       bits[i] = 1'b1;
                1:       bits[i] = (i % 2 == 0);
                default: bits[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Ones seen by the neuron output over the counted part of its stream.
    function automatic int exp_count();
        int n     = 0;
        int first = 0;
`ifdef SC_WARMUP_EN
        first = WU;
`endif
        for (int i = first; i < L; i++) n += int'(bits[i]);
        return n;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_stream_en"}, bus.stream_en, 0);
        chk({tag, "_neu_rst_n"}, bus.neu_rst_n, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
    endtask

    task automatic run_pass(input int mode, input int stall_k, input int stall_len,
                            input int abort_k, input int reset_k);
        int t0;
        int stalls = 0;
        int exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t0 = cyc;
        for (int k = 0; k < M; k++) begin
            chk("init_busy", bus.busy, 1);
            chk("init_stream_en", bus.stream_en, 0);
            chk("init_neu_rst_n", bus.neu_rst_n, 0);
            chk("init_neu_sel", bus.neu_sel, k);
            chk("init_res_valid", bus.res_valid, 0);
            fill_bits(mode);
            exp = exp_count();
            tick();
            chk("run_stream_en", bus.stream_en, 1);
            chk("run_neu_rst_n", bus.neu_rst_n, 1);
            for (int i = 0; i < L; i++) begin
                bus.neu_dout  = bits[i];
                bus.res_ready = 1'($urandom_range(0, 1));
                bus.start     = 1'($urandom_range(0, 1));
                if (k == abort_k && i == 99) begin
                    bus.start = 1'b0;
                    bus.abort = 1'b1;
                    tick();
                    bus.abort     = 1'b0;
                    bus.res_ready = 1'b1;
                    chk_idle("abort");
                    for (int j = 0; j < L + 5; j++) begin
                        tick();
                        chk("abort_no_valid", bus.res_valid, 0);
                        chk("abort_no_done", bus.done, 0);
                    end
                    bus.res_ready = 1'b0;
                    return;
                end
                tick();
            end
            bus.start     = 1'b0;
            bus.res_ready = 1'b0;
            bus.neu_dout  = 1'b0;
            chk("out_res_valid", bus.res_valid, 1);
            chk("out_res_idx", bus.res_idx, k);
            chk("out_res_count", bus.res_count, exp);
            chk("out_stream_en", bus.stream_en, 0);
            chk("out_neu_rst_n", bus.neu_rst_n, 1);
            if (k == reset_k) begin
                #2 reset = 1'b0;
                #1;
                chk_idle("areset");
                chk("areset_neu_sel", bus.neu_sel, 0);
                chk("areset_res_idx", bus.res_idx, 0);
                chk("areset_res_count", bus.res_count, 0);
                tick();
                reset = 1'b1;
                chk_idle("after_reset");
                return;
            end
            if (k == stall_k) begin
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    stalls++;
                    chk("stall_res_valid", bus.res_valid, 1);
                    chk("stall_res_idx", bus.res_idx, k);
                    chk("stall_res_count", bus.res_count, exp);
                    chk("stall_stream_en", bus.stream_en, 0);
                    chk("stall_neu_sel", bus.neu_sel, k);
                end
            end
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            chk("xfer_res_valid", bus.res_valid, 0);
        end
        chk("fin_done", bus.done, 1);
        chk("fin_latency", cyc - t0, M * (L + 2) + stalls);
        tick();
        chk_idle("post_fin");
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.neu_dout  = 1'b0;
        bus.res_ready = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_neu_sel", bus.neu_sel, 0);
        chk("reset_res_count", bus.res_count, 0);
        #20 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
        end

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_idle("start_abort");
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk_idle("ready_in_idle");

        run_pass(0, -1, 0, -1, -1);
        run_pass(1, 1, 10, -1, -1);
        run_pass(2, -1, 0, 2, -1);
        run_pass(2, 3, 3, -1, 1);
        run_pass(2, 0, 2, -1, -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("final_idle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
